sha256_msg_seq: RTL and testbench

- Sequencer for the SHA-256 message-schedule unit (delay0/run/in0/out0 interface, fixed latency).
- Accepts 512-bit message blocks as 16 big-endian 32-bit words over a valid/ready stream and buffers each block.
- Pulses run, feeds the 16 words on consecutive cycles, then re-times W0..W63 onto an indexed output stream for the round datapath.
- Handles multi-block messages; prefetches the next block while the current one drains.

---
 rtl/sha256_seq_pkg.sv | 20 ++
 rtl/sha256_msg_seq_if.sv | 41 ++++
 rtl/sha256_blk_buf.sv | 52 +++++
 rtl/sha256_msg_seq.sv | 168 ++++++++++++++++
 tb/tb_sha256_msg_seq.sv | 399 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sha256_seq_pkg.sv
// Shared types and constants for the SHA-256 message sequencer.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package sha256_seq_pkg;

    localparam int WORDS_PER_BLK = 16;
    localparam int ROUNDS        = 64;
    localparam int LAT_DEFAULT   = 17;

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        RUN,
        DELAY,
        FEED,
        DRAIN,
        DONE
    } seq_state_e;

endpackage

// File: rtl/sha256_msg_seq_if.sv
// Bundle of control, input stream, schedule-unit and W output signals.
// Latency: n/a (wiring only).
// Backpressure: s_ready gates the input stream; W output has none.
interface sha256_msg_seq_if #(
    parameter int DATA_W  = 32,
    parameter int DELAY_W = 32
);
    logic               start;
    logic [15:0]        cfg_nblocks;
    logic [DELAY_W-1:0] cfg_delay;
    logic               busy;
    logic               done;

    logic               s_valid;
    logic               s_ready;
    logic [DATA_W-1:0]  s_data;

    logic               unit_run;
    logic [DELAY_W-1:0] unit_delay0;
    logic [DATA_W-1:0]  unit_in0;
    logic [DATA_W-1:0]  unit_out0;

    logic               w_valid;
    logic [DATA_W-1:0]  w_data;
    logic [5:0]         w_idx;
    logic               w_blk_last;

    // Sequencer side.
    modport slave (
        input  start, cfg_nblocks, cfg_delay, s_valid, s_data, unit_out0,
        output busy, done, s_ready, unit_run, unit_delay0, unit_in0,
               w_valid, w_data, w_idx, w_blk_last
    );

    // Environment side: host, word source, schedule unit, round datapath.
    modport master (
        output start, cfg_nblocks, cfg_delay, s_valid, s_data, unit_out0,
        input  busy, done, s_ready, unit_run, unit_delay0, unit_in0,
               w_valid, w_data, w_idx, w_blk_last
    );
endinterface

// File: rtl/sha256_blk_buf.sv
// 16-word block buffer: writes land at index count, reads are random access.
// Latency: write visible on the cycle after wr_vld; read is combinational.
// Backpressure: writes are dropped once full; caller gates with count.
module sha256_blk_buf
    import sha256_seq_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_vld,
    input  logic [DATA_W-1:0] wr_dat,
    input  logic              clr,
    input  logic [3:0]        rd_idx,
    output logic [DATA_W-1:0] rd_dat,
    output logic [4:0]        count
);

    logic [DATA_W-1:0] mem_q [WORDS_PER_BLK];
    logic [DATA_W-1:0] mem_d [WORDS_PER_BLK];
    logic [4:0]        count_q;
    logic [4:0]        count_d;

    // Append on write; clear wins so the next block starts at index 0.
    always_comb begin
        mem_d   = mem_q;
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (wr_vld && !count_q[4]) begin
            mem_d[count_q[3:0]] = wr_dat;
            count_d             = count_q + 5'd1;
        end
    end

    // Buffer storage and fill count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
            for (int i = 0; i < WORDS_PER_BLK; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            count_q <= count_d;
            mem_q   <= mem_d;
        end
    end

    assign rd_dat = mem_q[rd_idx];
    assign count  = count_q;

endmodule

// File: rtl/sha256_msg_seq.sv
// Sequencer feeding buffered message blocks to the schedule unit and emitting W0..W63.
// Latency: W0 at run+1+cfg_delay, W16 at W0+LAT, done one cycle after the last W63.
// Backpressure: s_ready drops while the buffer is full; the W stream cannot stall.
module sha256_msg_seq
    import sha256_seq_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int DELAY_W = 32,
    parameter int LAT     = LAT_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    sha256_msg_seq_if.slave      io
);

    // Cycle counter c runs from feed cycle 0 through the last drained word.
    localparam logic [6:0] C_FEED_LAST = 7'(WORDS_PER_BLK - 1);
    localparam logic [6:0] C_W16       = 7'(LAT);
    localparam logic [6:0] C_LAST      = 7'(LAT + ROUNDS - WORDS_PER_BLK - 1);
    localparam logic [5:0] IDX_OFS     = 6'(WORDS_PER_BLK - LAT);

    seq_state_e         state_q, state_d;
    logic [6:0]         c_q, c_d;
    logic [DELAY_W-1:0] dly_q, dly_d;
    logic [DELAY_W-1:0] dcfg_q, dcfg_d;
    logic [15:0]        blk_left_q, blk_left_d;
    logic [15:0]        fetch_left_q, fetch_left_d;

    logic               busy;
    logic               s_rdy;
    logic               buf_wr;
    logic               buf_clr;
    logic               buf_full;
    logic [4:0]         buf_cnt;
    logic [DATA_W-1:0]  buf_rd;

    assign busy     = (state_q == FILL) || (state_q == RUN) || (state_q == DELAY) ||
                      (state_q == FEED) || (state_q == DRAIN);
    assign buf_full = buf_cnt[4];
    assign s_rdy    = busy && !buf_full && (fetch_left_q != 16'd0);
    assign buf_wr   = io.s_valid && s_rdy;

    sha256_blk_buf #(
        .DATA_W (DATA_W)
    ) u_buf (
        .clk    (clk),
        .rst    (rst),
        .wr_vld (buf_wr),
        .wr_dat (io.s_data),
        .clr    (buf_clr),
        .rd_idx (c_q[3:0]),
        .rd_dat (buf_rd),
        .count  (buf_cnt)
    );

    // Next-state logic; fetch accounting runs alongside so refill overlaps drain.
    always_comb begin
        state_d      = state_q;
        c_d          = c_q;
        dly_d        = dly_q;
        dcfg_d       = dcfg_q;
        blk_left_d   = blk_left_q;
        fetch_left_d = fetch_left_q;
        buf_clr      = 1'b0;

        if (buf_wr && (buf_cnt == 5'd15)) begin
            fetch_left_d = fetch_left_q - 16'd1;
        end

        unique case (state_q)
            IDLE: begin
                if (io.start) begin
                    dcfg_d       = io.cfg_delay;
                    blk_left_d   = io.cfg_nblocks;
                    fetch_left_d = io.cfg_nblocks;
                    state_d      = (io.cfg_nblocks == 16'd0) ? DONE : FILL;
                end
            end
            FILL: begin
                if (buf_full) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                c_d     = '0;
                dly_d   = dcfg_q;
                state_d = (dcfg_q == '0) ? FEED : DELAY;
            end
            DELAY: begin
                dly_d = dly_q - DELAY_W'(1);
                if (dly_q == DELAY_W'(1)) begin
                    state_d = FEED;
                end
            end
            FEED: begin
                c_d = c_q + 7'd1;
                if (c_q == C_FEED_LAST) begin
                    buf_clr = 1'b1;
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                c_d = c_q + 7'd1;
                if (c_q == C_LAST) begin
                    blk_left_d = blk_left_q - 16'd1;
                    if (blk_left_q != 16'd1) begin
                        state_d = buf_full ? RUN : FILL;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Sequencer state and counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            c_q          <= '0;
            dly_q        <= '0;
            dcfg_q       <= '0;
            blk_left_q   <= '0;
            fetch_left_q <= '0;
        end else begin
            state_q      <= state_d;
            c_q          <= c_d;
            dly_q        <= dly_d;
            dcfg_q       <= dcfg_d;
            blk_left_q   <= blk_left_d;
            fetch_left_q <= fetch_left_d;
        end
    end

    // Output decode: buffer words during FEED, unit words once W16 arrives.
    always_comb begin
        io.unit_in0   = '0;
        io.w_valid    = 1'b0;
        io.w_data     = '0;
        io.w_idx      = '0;
        io.w_blk_last = 1'b0;
        if (state_q == FEED) begin
            io.unit_in0   = buf_rd;
            io.w_valid    = 1'b1;
            io.w_data     = buf_rd;
            io.w_idx      = c_q[5:0];
            io.w_blk_last = (blk_left_q == 16'd1);
        end else if ((state_q == DRAIN) && (c_q >= C_W16)) begin
            io.w_valid    = 1'b1;
            io.w_data     = io.unit_out0;
            io.w_idx      = c_q[5:0] + IDX_OFS;
            io.w_blk_last = (blk_left_q == 16'd1);
        end
    end

    assign io.busy        = busy;
    assign io.done        = (state_q == DONE);
    assign io.s_ready     = s_rdy;
    assign io.unit_run    = (state_q == RUN);
    assign io.unit_delay0 = dcfg_q;

endmodule

// File: tb/tb_sha256_msg_seq.sv
// Bench for sha256_msg_seq with a cycle model of the schedule unit and a W scoreboard.
// Latency: the unit model returns W16+j at feed cycle 0 + LAT + j.
// Backpressure: the word source inserts random gaps and holds words until accepted.
module tb_sha256_msg_seq;
    import sha256_seq_pkg::*;

    localparam int DATA_W  = 32;
    localparam int DELAY_W = 32;
    localparam int LAT     = 17;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sha256_msg_seq_if #(.DATA_W(DATA_W), .DELAY_W(DELAY_W)) iface ();

    sha256_msg_seq #(.DATA_W(DATA_W), .DELAY_W(DELAY_W), .LAT(LAT)) dut (
        .clk (clk),
        .rst (rst),
        .io  (iface)
    );

    wire [107:0] outs = {iface.busy, iface.done, iface.s_ready, iface.unit_run,
                         iface.unit_delay0, iface.unit_in0, iface.w_valid,
                         iface.w_data, iface.w_idx, iface.w_blk_last};

    int cmp = 0;
    int mis = 0;
    int cyc = 0;

    int          rec_cyc[$];
    logic [5:0]  rec_idx[$];
    logic [31:0] rec_dat[$];
    logic        rec_last[$];
    int          run_cyc[$];
    logic [31:0] run_dly[$];
    int          done_cyc[$];
    int          busy_n, rdy_n;
    logic [31:0] exp_dat[$];
    logic [5:0]  exp_idx[$];
    logic        exp_last[$];
    logic [31:0] msg[$];

    function automatic logic [31:0] rotr(logic [31:0] x, int n);
        return (x >> n) | (x << (32 - n));
    endfunction
    function automatic logic [31:0] ssig0(logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction
    function automatic logic [31:0] ssig1(logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    // Schedule unit model: captures 16 fed words, expands them, replays after LAT.
    logic [31:0] um_w[64];
    int          um_feed0 = -1;
    logic [31:0] um_nxt = '0;

    always @(negedge clk) begin
        int m;
        cyc++;
        if (rst) begin
            um_feed0 = -1;
        end else begin
            if (iface.unit_run) um_feed0 = cyc + 1 + int'(iface.unit_delay0);
            if (um_feed0 >= 0 && cyc >= um_feed0 && cyc - um_feed0 < 16) begin
                um_w[cyc - um_feed0] = iface.unit_in0;
                if (cyc - um_feed0 == 15)
                    for (int t = 16; t < ROUNDS; t++)
                        um_w[t] = ssig1(um_w[t-2]) + um_w[t-7] + ssig0(um_w[t-15]) + um_w[t-16];
            end
        end
        m = cyc + 1 - um_feed0;
        if (um_feed0 >= 0 && m >= LAT && m < LAT + 48) um_nxt = um_w[16 + m - LAT];
        else um_nxt = $urandom;
        // Recorder of observable events.
        if (iface.w_valid) begin
            rec_cyc.push_back(cyc);
            rec_idx.push_back(iface.w_idx);
            rec_dat.push_back(iface.w_data);
            rec_last.push_back(iface.w_blk_last);
        end
        if (iface.unit_run) begin
            run_cyc.push_back(cyc);
            run_dly.push_back(iface.unit_delay0);
        end
        if (iface.done) done_cyc.push_back(cyc);
        if (iface.busy) busy_n++;
        if (iface.s_ready) rdy_n++;
    end

    initial begin
        iface.unit_out0 = '0;
        forever begin
            @(posedge clk);
            #1;
            iface.unit_out0 = um_nxt;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic rand_msg(input int nblk);
        msg.delete();
        for (int i = 0; i < nblk * 16; i++) msg.push_back($urandom);
    endtask

    task automatic abc_msg();
        msg.delete();
        msg.push_back(32'h61626380);
        for (int i = 0; i < 14; i++) msg.push_back(32'h0);
        msg.push_back(32'h00000018);
    endtask

    // Runs one message: builds expected W stream, drives start and words, waits for done.
    task automatic run_msg(input int nblk, input int dly, input int gap_pct, input int ign_at,
                           input int abort_idx, output int start_c, output bit aborted);
        logic [31:0] sw[64];
        int  wi, k;
        bit  fin, acc;
        exp_dat.delete(); exp_idx.delete(); exp_last.delete();
        rec_cyc.delete(); rec_idx.delete(); rec_dat.delete(); rec_last.delete();
        run_cyc.delete(); run_dly.delete(); done_cyc.delete();
        busy_n = 0; rdy_n = 0;
        for (int b = 0; b < nblk; b++) begin
            for (int t = 0; t < 16; t++) sw[t] = msg[b*16 + t];
            for (int t = 16; t < ROUNDS; t++)
                sw[t] = ssig1(sw[t-2]) + sw[t-7] + ssig0(sw[t-15]) + sw[t-16];
            for (int t = 0; t < ROUNDS; t++) begin
                exp_dat.push_back(sw[t]);
                exp_idx.push_back(6'(t));
                exp_last.push_back(b == nblk - 1);
            end
        end
        @(posedge clk); #1;
        iface.cfg_nblocks = 16'(nblk);
        iface.cfg_delay   = 32'(dly);
        iface.start       = 1'b1;
        start_c = cyc + 1;
        wi = 0; k = 0; fin = 0; aborted = 0;
        iface.s_valid = 1'b0;
        while (!fin && k < 4000) begin
            if (k > 0) begin
                iface.start = (k == ign_at);
                if (k == ign_at) begin
                    iface.cfg_nblocks = 16'd3;
                    iface.cfg_delay   = 32'd7;
                end
            end
            if (!iface.s_valid && wi < msg.size() && $urandom_range(99) >= gap_pct) begin
                iface.s_valid = 1'b1;
                iface.s_data  = msg[wi];
            end
            @(negedge clk);
            acc = iface.s_valid && iface.s_ready;
            if (acc) wi++;
            if (iface.done) fin = 1;
            if (abort_idx >= 0 && iface.w_valid && int'(iface.w_idx) == abort_idx) begin
                rst = 1'b1; aborted = 1; fin = 1;
            end
            @(posedge clk); #1;
            if (acc) iface.s_valid = 1'b0;
            k++;
        end
        iface.start = 1'b0;
        iface.s_valid = 1'b0;
        cmp++;
        if (!fin) begin
            mis++;
            $display("FAIL run_timeout: done=0 after %0d cycles, required done pulse", k);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        cmp++;
        if (outs !== '0) begin
            mis++; $display("FAIL reset_outs: got %h, required 0", outs);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        cmp++;
        if (outs !== '0) begin
            mis++; $display("FAIL idle_outs: got %h, required 0", outs);
        end
    endtask

    task automatic test_abc();
        int sc; bit ab;
        logic [31:0] w16, w17, w63;
        int d0, l63, r0, c0, c16;
        abc_msg();
        run_msg(1, 0, 0, -1, -1, sc, ab);
        cmp++;
        if (rec_dat.size() != 64) begin
            mis++; $display("FAIL abc_count: got %0d W, required 64", rec_dat.size());
        end
        for (int i = 0; i < exp_dat.size(); i++) begin
            cmp++;
            if (i >= rec_dat.size()) begin
                mis++; $display("FAIL abc_w[%0d]: missing, required %h", i, exp_dat[i]);
            end else if ({rec_idx[i], rec_dat[i], rec_last[i]} !== {exp_idx[i], exp_dat[i], exp_last[i]}) begin
                mis++; $display("FAIL abc_w[%0d]: got idx=%0d dat=%h last=%0d, required idx=%0d dat=%h last=%0d",
                                i, rec_idx[i], rec_dat[i], rec_last[i], exp_idx[i], exp_dat[i], exp_last[i]);
            end
        end
        w16 = (rec_dat.size() > 16) ? rec_dat[16] : 'x;
        w17 = (rec_dat.size() > 17) ? rec_dat[17] : 'x;
        w63 = (rec_dat.size() > 63) ? rec_dat[63] : 'x;
        cmp++; if (w16 !== 32'h61626380) begin mis++; $display("FAIL abc_w16: got %h, required 61626380", w16); end
        cmp++; if (w17 !== 32'h000F0000) begin mis++; $display("FAIL abc_w17: got %h, required 000f0000", w17); end
        cmp++; if (w63 !== 32'h12B1EDEB) begin mis++; $display("FAIL abc_w63: got %h, required 12b1edeb", w63); end
        d0  = (done_cyc.size() == 1) ? done_cyc[0] : -100;
        l63 = (rec_cyc.size() > 63) ? rec_cyc[63] : -200;
        cmp++;
        if (d0 != l63 + 1) begin
            mis++; $display("FAIL abc_done: done at %0d (count %0d), required %0d", d0, done_cyc.size(), l63 + 1);
        end
        r0  = (run_cyc.size() == 1) ? run_cyc[0] : -300;
        c0  = (rec_cyc.size() > 0) ? rec_cyc[0] : -400;
        c16 = (rec_cyc.size() > 16) ? rec_cyc[16] : -400;
        cmp++;
        if (c0 != r0 + 1 || c16 != r0 + 1 + LAT) begin
            mis++; $display("FAIL abc_timing: W0 at %0d W16 at %0d, required %0d and %0d", c0, c16, r0 + 1, r0 + 1 + LAT);
        end
    endtask

    task automatic test_delay();
        int sc; bit ab;
        int r0, c0, c15, c16;
        logic [31:0] d;
        rand_msg(1);
        run_msg(1, 5, 0, -1, -1, sc, ab);
        d   = (run_dly.size() == 1) ? run_dly[0] : 'x;
        r0  = (run_cyc.size() == 1) ? run_cyc[0] : -300;
        c0  = (rec_cyc.size() > 0) ? rec_cyc[0] : -400;
        c15 = (rec_cyc.size() > 15) ? rec_cyc[15] : -400;
        c16 = (rec_cyc.size() > 16) ? rec_cyc[16] : -400;
        cmp++; if (d !== 32'd5) begin mis++; $display("FAIL delay_cfg: unit_delay0=%0d, required 5", d); end
        cmp++; if (c0 != r0 + 6) begin mis++; $display("FAIL delay_w0: at %0d, required %0d", c0, r0 + 6); end
        cmp++; if (c16 != r0 + 6 + LAT) begin mis++; $display("FAIL delay_w16: at %0d, required %0d", c16, r0 + 6 + LAT); end
        cmp++; if (c16 - c15 != LAT - 15) begin mis++; $display("FAIL delay_gap: %0d, required %0d", c16 - c15, LAT - 15); end
        cmp++;
        if (rec_dat.size() != exp_dat.size()) begin
            mis++; $display("FAIL delay_count: got %0d, required %0d", rec_dat.size(), exp_dat.size());
        end
        for (int i = 0; i < exp_dat.size() && i < rec_dat.size(); i++) begin
            cmp++;
            if ({rec_idx[i], rec_dat[i], rec_last[i]} !== {exp_idx[i], exp_dat[i], exp_last[i]}) begin
                mis++; $display("FAIL delay_w[%0d]: got idx=%0d dat=%h, required idx=%0d dat=%h",
                                i, rec_idx[i], rec_dat[i], exp_idx[i], exp_dat[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int sc; bit ab;
        int r1, l63, d0, l127;
        rand_msg(2);
        run_msg(2, 0, 0, -1, -1, sc, ab);
        cmp++;
        if (rec_dat.size() != 128 || run_cyc.size() != 2) begin
            mis++; $display("FAIL b2b_count: got %0d W %0d runs, required 128 and 2", rec_dat.size(), run_cyc.size());
        end
        r1  = (run_cyc.size() > 1) ? run_cyc[1] : -300;
        l63 = (rec_cyc.size() > 63) ? rec_cyc[63] : -400;
        cmp++;
        if (r1 != l63 + 1) begin
            mis++; $display("FAIL b2b_run2: second run at %0d, required %0d", r1, l63 + 1);
        end
        for (int i = 0; i < exp_dat.size() && i < rec_dat.size(); i++) begin
            cmp++;
            if ({rec_idx[i], rec_dat[i], rec_last[i]} !== {exp_idx[i], exp_dat[i], exp_last[i]}) begin
                mis++; $display("FAIL b2b_w[%0d]: got idx=%0d dat=%h last=%0d, required idx=%0d dat=%h last=%0d",
                                i, rec_idx[i], rec_dat[i], rec_last[i], exp_idx[i], exp_dat[i], exp_last[i]);
            end
        end
        d0   = (done_cyc.size() == 1) ? done_cyc[0] : -100;
        l127 = (rec_cyc.size() > 127) ? rec_cyc[127] : -200;
        cmp++;
        if (d0 != l127 + 1) begin
            mis++; $display("FAIL b2b_done: done at %0d, required %0d", d0, l127 + 1);
        end
    endtask

    task automatic test_gaps();
        int sc; bit ab;
        logic [31:0] nogap[$];
        int span;
        rand_msg(3);
        run_msg(3, 1, 0, -1, -1, sc, ab);
        nogap = rec_dat;
        run_msg(3, 1, 50, -1, -1, sc, ab);
        cmp++;
        if (rec_dat.size() != 192) begin
            mis++; $display("FAIL gap_count: got %0d W, required 192", rec_dat.size());
        end
        for (int b = 0; b < 3; b++) begin
            span = (rec_cyc.size() > b*64 + 15) ? rec_cyc[b*64 + 15] - rec_cyc[b*64] : -1;
            cmp++;
            if (span != 15) begin
                mis++; $display("FAIL gap_feed_blk%0d: feed span %0d cycles, required 15", b, span);
            end
        end
        for (int i = 0; i < exp_dat.size() && i < rec_dat.size(); i++) begin
            cmp++;
            if ({rec_idx[i], rec_dat[i], rec_last[i]} !== {exp_idx[i], exp_dat[i], exp_last[i]} ||
                (i < nogap.size() && rec_dat[i] !== nogap[i])) begin
                mis++; $display("FAIL gap_w[%0d]: got idx=%0d dat=%h last=%0d, required idx=%0d dat=%h last=%0d",
                                i, rec_idx[i], rec_dat[i], rec_last[i], exp_idx[i], exp_dat[i], exp_last[i]);
            end
        end
    endtask

    task automatic test_zero_blocks();
        int sc; bit ab;
        int d0;
        logic [31:0] d;
        msg.delete();
        run_msg(0, 0, 0, -1, -1, sc, ab);
        d0 = (done_cyc.size() == 1) ? done_cyc[0] : -100;
        cmp++;
        if (d0 != sc + 1) begin
            mis++; $display("FAIL zero_done: done at %0d (count %0d), required %0d", d0, done_cyc.size(), sc + 1);
        end
        cmp++;
        if (busy_n != 0 || rdy_n != 0) begin
            mis++; $display("FAIL zero_quiet: busy cycles %0d s_ready cycles %0d, required 0 and 0", busy_n, rdy_n);
        end
        // Second start while busy must not reload block count or delay.
        rand_msg(1);
        run_msg(1, 2, 0, 10, -1, sc, ab);
        d = (run_dly.size() == 1) ? run_dly[0] : 'x;
        cmp++;
        if (rec_dat.size() != 64 || run_cyc.size() != 1 || done_cyc.size() != 1 || d !== 32'd2) begin
            mis++; $display("FAIL ign_start: %0d W %0d runs %0d dones delay=%0d, required 64 1 1 2",
                            rec_dat.size(), run_cyc.size(), done_cyc.size(), d);
        end
        cmp++;
        if (rdy_n != 16) begin
            mis++; $display("FAIL ign_ready: s_ready high %0d cycles, required 16", rdy_n);
        end
        for (int i = 0; i < exp_dat.size() && i < rec_dat.size(); i++) begin
            cmp++;
            if ({rec_idx[i], rec_dat[i], rec_last[i]} !== {exp_idx[i], exp_dat[i], exp_last[i]}) begin
                mis++; $display("FAIL ign_w[%0d]: got idx=%0d dat=%h last=%0d, required idx=%0d dat=%h last=1",
                                i, rec_idx[i], rec_dat[i], rec_last[i], exp_idx[i], exp_dat[i]);
            end
        end
    endtask

    task automatic test_rst_mid();
        int sc; bit ab;
        rand_msg(2);
        run_msg(2, 0, 0, -1, 30, sc, ab);
        cmp++;
        if (!ab) begin
            mis++; $display("FAIL rst_reach: w_idx=30 not observed, required abort point");
        end
        @(negedge clk);
        cmp++;
        if (outs !== '0) begin
            mis++; $display("FAIL rst_outs: got %h, required 0", outs);
        end
        repeat (3) @(negedge clk);
        cmp++;
        if (done_cyc.size() != 0) begin
            mis++; $display("FAIL rst_nodone: %0d done pulses, required 0", done_cyc.size());
        end
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        test_abc();
    endtask

    initial begin
        iface.start       = 1'b0;
        iface.cfg_nblocks = '0;
        iface.cfg_delay   = '0;
        iface.s_valid     = 1'b0;
        iface.s_data      = '0;
        test_reset();
        test_abc();
        test_delay();
        test_back_to_back();
        test_gaps();
        test_zero_blocks();
        test_rst_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, mis);
        $finish;
    end

endmodule
